bcd_share_sched: RTL and testbench

Round-robin scheduler that time-shares one 7-bit binary-to-BCD converter among `N_REQ` requesters (score, timer and counter sources in the final-project top level). It stores each channel's converted 3-digit BCD result and scans all stored digits out, one at a time, to the seven-segment digit driver. It sits between the game-logic blocks and the display decoder.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_conv7.sv | 21 ++
 rtl/bcd_share_sched.sv | 153 +++++++++++++++
 tb/tb_bcd_share_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the shared binary-to-BCD scheduler.
package bcd_pkg;
   localparam int BIN_W = 7;
   localparam int BCD_W = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam logic [1:0] DIG_ONES = 2'd0;
   localparam logic [1:0] DIG_TENS = 2'd1;
   localparam logic [1:0] DIG_HUND = 2'd2;
endpackage

// File: rtl/bcd_conv7.sv
// Combinational 7-bit double-dabble converter: {hundreds[0], tens, ones}.
module bcd_conv7
   import bcd_pkg::*;
(
   input  logic [BIN_W-1:0] i_bin,
   output logic [BCD_W-1:0] o_bcd
);
   // {hundreds, tens, ones, binary} shift register, 1+4+4+7 bits
   logic [BCD_W+BIN_W-1:0] w_sh;

   always_comb begin
      w_sh = {{BCD_W{1'b0}}, i_bin};
      for (int k = 0; k < BIN_W; k++) begin
         if (w_sh[10:7] >= 4'd5)  w_sh[10:7]  = w_sh[10:7]  + 4'd3;
         if (w_sh[14:11] >= 4'd5) w_sh[14:11] = w_sh[14:11] + 4'd3;
         w_sh = w_sh << 1;
      end
   end

   assign o_bcd = w_sh[BCD_W+BIN_W-1:BIN_W];
endmodule

// File: rtl/bcd_share_sched.sv
// Round-robin time-sharing of one binary-to-BCD converter across N_REQ
// channels, with per-channel result storage and a multiplexed digit scan.
module bcd_share_sched
   import bcd_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int SCAN_DIV = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [BIN_W*N_REQ-1:0]   req_value,
   output logic [N_REQ-1:0]         req_ready,
   output logic [BCD_W*N_REQ-1:0]   ch_bcd,
   output logic [N_REQ-1:0]         ch_done,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] scan_ch,
   output logic [1:0]               scan_digit,
   output logic [3:0]               scan_nibble,
   output logic                     scan_blank,
   output logic [1:0]               dbg_state
);
   localparam int CH_W  = $clog2(N_REQ);
   localparam int DIV_W = $clog2(SCAN_DIV);

   // Handshake: a channel transfers on the rising edge where req_valid[i]
   // and req_ready[i] are both high; req_ready is one-hot and only in IDLE.

   // First valid channel searching cyclically from last+1; the loop runs
   // backwards so the smallest offset is the one that sticks.
   function automatic logic [CH_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [CH_W-1:0]  last);
      logic [CH_W-1:0] pick;
      int              idx;
      pick = last;
      for (int off = N_REQ; off >= 1; off--) begin
         idx = (int'(last) + off) % N_REQ;
         if (valid[idx]) pick = CH_W'(idx);
      end
      return pick;
   endfunction

   state_t                   r_state, w_next;
   logic [CH_W-1:0]          r_last, r_cur, w_grant;
   logic [BIN_W-1:0]         r_hold;
   logic [BCD_W-1:0]         r_res, w_conv, w_slot;
   logic [BCD_W*N_REQ-1:0]   r_ch_bcd;
   logic [N_REQ-1:0]         r_ch_done, w_ready;
   logic                     w_any;
   logic [DIV_W-1:0]         r_div;
   logic [CH_W-1:0]          r_scan_ch;
   logic [1:0]               r_scan_digit;

   assign w_any   = |req_valid;
   assign w_grant = rr_pick(req_valid, r_last);

   bcd_conv7 u_conv (
      .i_bin (r_hold),
      .o_bcd (w_conv)
   );

   always_comb begin
      w_next  = r_state;
      w_ready = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_ready[w_grant] = 1'b1;
               w_next           = CONV;
            end
         end
         CONV:    w_next = WRITE;
         WRITE:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last    <= CH_W'(N_REQ - 1);
         r_cur     <= '0;
         r_hold    <= '0;
         r_res     <= '0;
         r_ch_bcd  <= '0;
         r_ch_done <= '0;
      end else begin
         r_state   <= w_next;
         r_ch_done <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_hold <= req_value[w_grant*BIN_W +: BIN_W];
                  r_cur  <= w_grant;
                  r_last <= w_grant;
               end
            end
            CONV: r_res <= w_conv;
            WRITE: begin
               r_ch_bcd[r_cur*BCD_W +: BCD_W] <= r_res;
               r_ch_done[r_cur]               <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Digit scan: ones, tens, hundreds per channel, then next channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div        <= '0;
         r_scan_ch    <= '0;
         r_scan_digit <= DIG_ONES;
      end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
         r_div <= '0;
         if (r_scan_digit == DIG_HUND) begin
            r_scan_digit <= DIG_ONES;
            r_scan_ch    <= (r_scan_ch == CH_W'(N_REQ - 1)) ? '0 : r_scan_ch + 1'b1;
         end else begin
            r_scan_digit <= r_scan_digit + 1'b1;
         end
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign w_slot = r_ch_bcd[r_scan_ch*BCD_W +: BCD_W];

   always_comb begin
      scan_nibble = 4'd0;
      scan_blank  = 1'b0;
      case (r_scan_digit)
         DIG_ONES: scan_nibble = w_slot[3:0];
         DIG_TENS: begin
            scan_nibble = w_slot[7:4];
            scan_blank  = ~w_slot[8] & (w_slot[7:4] == 4'd0);
         end
         DIG_HUND: begin
            scan_nibble = {3'b000, w_slot[8]};
            scan_blank  = ~w_slot[8];
         end
         default: ;
      endcase
   end

   assign req_ready  = w_ready;
   assign ch_bcd     = r_ch_bcd;
   assign ch_done    = r_ch_done;
   assign busy       = (r_state != IDLE);
   assign scan_ch    = r_scan_ch;
   assign scan_digit = r_scan_digit;
   assign dbg_state  = r_state;
endmodule

// File: tb/tb_bcd_share_sched.sv
// Randomized scoreboard bench for bcd_share_sched against an arithmetic model.
module tb_bcd_share_sched;
   localparam int N  = 4;
   localparam int SD = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [7*N-1:0] req_value = '0;
   logic [N-1:0]   req_ready, ch_done;
   logic [9*N-1:0] ch_bcd;
   logic           busy, scan_blank;
   logic [1:0]     scan_ch, scan_digit, dbg_state;
   logic [3:0]     scan_nibble;

   bcd_share_sched #(.N_REQ(N), .SCAN_DIV(SD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_value   (req_value),
      .req_ready   (req_ready),
      .ch_bcd      (ch_bcd),
      .ch_done     (ch_done),
      .busy        (busy),
      .scan_ch     (scan_ch),
      .scan_digit  (scan_digit),
      .scan_nibble (scan_nibble),
      .scan_blank  (scan_blank),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int e_cnt    = 0;

   // entry = {channel[3], value[7], due cycle[32]}
   logic [41:0] exp_q[$];
   int  m_val[N];
   int  m_last    = N - 1;
   int  m_next_ok = 0;
   bit  acc[N];
   bit  drv_valid[N];
   int  drv_val[N];
   bit  keep[N];
   int  served[N];

   function automatic logic [8:0] to_bcd(input int v);
      logic [8:0] r;
      r[8]   = (v >= 100);
      r[7:4] = 4'((v / 10) % 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rst) e_cnt++;
   end

   // Monitor: retires due results, tracks stored values, checks slots and scan.
   always @(negedge clk) begin
      logic [41:0] e;
      logic [N-1:0] exp_done;
      int d, sc, v, nib;
      bit blank;
      exp_done = '0;
      if (!rst && exp_q.size() > 0 && int'(exp_q[0][31:0]) == cyc) begin
         e = exp_q.pop_front();
         exp_done[int'(e[41:39])] = 1'b1;
         m_val[int'(e[41:39])]    = int'(e[38:32]);
      end
      check("ch_done", 64'(ch_done), 64'(exp_done));
      for (int i = 0; i < N; i++)
         check($sformatf("ch_bcd%0d", i), 64'(ch_bcd[9*i +: 9]), 64'(to_bcd(m_val[i])));
      d  = (e_cnt / SD) % 3;
      sc = (e_cnt / (3 * SD)) % N;
      v  = m_val[sc];
      nib   = (d == 0) ? v % 10 : (d == 1) ? (v / 10) % 10 : v / 100;
      blank = (d == 2 && v < 100) || (d == 1 && v < 10);
      check("scan_ch", 64'(scan_ch), 64'(sc));
      check("scan_digit", 64'(scan_digit), 64'(d));
      check("scan_nibble", 64'(scan_nibble), 64'(nib));
      check("scan_blank", 64'(scan_blank), 64'(blank));
   end

   // Reference scheduler: predicts grants and busy, pushes expected results.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int g;
      if (rst) begin
         m_last    = N - 1;
         m_next_ok = 0;
      end else if (cyc >= m_next_ok) begin
         exp_rdy = '0;
         g = -1;
         for (int off = 1; off <= N; off++)
            if (g < 0 && drv_valid[(m_last + off) % N]) g = (m_last + off) % N;
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("req_ready", 64'(req_ready), 64'(exp_rdy));
         check("busy_idle", 64'(busy), 64'd0);
         if (g >= 0) begin
            exp_q.push_back({3'(g), 7'(drv_val[g]), 32'(cyc + 3)});
            m_last    = g;
            m_next_ok = cyc + 3;
            acc[g]    = 1'b1;
         end
      end else begin
         check("req_ready_busy", 64'(req_ready), 64'd0);
         check("busy_conv", 64'(busy), 64'd1);
      end
   end

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = drv_valid[i];
         req_value[7*i +: 7]  = 7'(drv_val[i]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            acc[i] = 1'b0;
            served[i]++;
            if (keep[i]) drv_val[i] = int'($urandom_range(0, 127));
            else         drv_valid[i] = 1'b0;
         end
      end
      apply();
   endtask

   task automatic request(input int ch, input int v);
      drv_valid[ch] = 1'b1;
      drv_val[ch]   = v;
      keep[ch]      = 1'b0;
      apply();
   endtask

   task automatic wait_served(input int ch, input int target, input int budget);
      int n = 0;
      while (served[ch] < target && n < budget) begin
         step();
         n++;
      end
      check($sformatf("served_ch%0d", ch), 64'(served[ch] >= target), 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      bit pend = 1'b1;
      while (pend && n < 200) begin
         pend = (exp_q.size() > 0);
         for (int i = 0; i < N; i++) if (drv_valid[i]) pend = 1'b1;
         if (pend) step();
         n++;
      end
      check("drain", 64'(pend), 64'd0);
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      exp_q.delete();
      e_cnt = 0;
      for (int i = 0; i < N; i++) begin
         m_val[i]     = 0;
         acc[i]       = 1'b0;
         drv_valid[i] = 1'b0;
         keep[i]      = 1'b0;
      end
      apply();
      repeat (ncyc) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int s1;
      for (int i = 0; i < N; i++) begin
         m_val[i] = 0; acc[i] = 0; drv_valid[i] = 0; drv_val[i] = 0; keep[i] = 0; served[i] = 0;
      end
      apply();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // single request, full-scale value
      request(0, 127);
      wait_served(0, 1, 20);
      wait_drain();

      // all four at once after reset: rotation starts at channel 0
      do_reset(2);
      request(0, 5); request(1, 42); request(2, 99); request(3, 0);
      wait_served(3, served[3] + 1, 40);
      wait_drain();

      // ch2 hammers continuously, ch1 must still get through
      request(2, 17);
      keep[2] = 1'b1;
      request(1, 55);
      wait_served(1, served[1] + 1, 30);
      keep[2] = 1'b0;
      wait_drain();

      // value changes right after accept must not affect the result
      request(3, 64);
      wait_served(3, served[3] + 1, 20);
      drv_val[3] = 10;
      apply();
      wait_drain();

      // reset while converting, then a normal request
      request(1, 77);
      wait_served(1, served[1] + 1, 20);
      do_reset(3);
      request(0, 33);
      wait_served(0, served[0] + 1, 20);
      wait_drain();

      // scan of a small value from a clean start
      do_reset(2);
      request(0, 7);
      wait_drain();
      repeat (40) step();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!drv_valid[i] && $urandom_range(0, 3) == 0) begin
               drv_valid[i] = 1'b1;
               drv_val[i]   = int'($urandom_range(0, 127));
               keep[i]      = ($urandom_range(0, 3) == 0);
            end else if (drv_valid[i] && !keep[i] && $urandom_range(0, 7) == 0) begin
               drv_valid[i] = 1'b0;
            end
         end
         apply();
         step();
      end
      for (int i = 0; i < N; i++) keep[i] = 1'b0;
      wait_drain();
      s1 = exp_q.size();
      check("queue_empty", 64'(s1), 64'd0);
      repeat (5) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
